// File: rtl/jogo_pkg.sv
// Shared definitions for the board checkers: cell/macro encodings, the eight
// winning lines and the checker FSM states.
package jogo_pkg;

    localparam logic [1:0] VAZIO = 2'b00;
    localparam logic [1:0] JOG1  = 2'b01;
    localparam logic [1:0] JOG2  = 2'b10;

    localparam logic [1:0] ANDAMENTO = 2'b00;
    localparam logic [1:0] VENC1     = 2'b01;
    localparam logic [1:0] VENC2     = 2'b10;
    localparam logic [1:0] VELHA     = 2'b11;

    localparam int NUM_CELULAS = 9;
    localparam int NUM_LINHAS  = 8;

    // Rows, columns, then the two diagonals, as micro-cell indices.
    localparam logic [3:0] LINHAS [NUM_LINHAS][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    typedef enum logic [2:0] {
        OCIOSO,
        LEITURA,
        AVALIA,
        ESCREVE,
        FIM
    } estado_t;

    function automatic logic jogador_valido(input logic [1:0] jog);
        return (jog == JOG1) || (jog == JOG2);
    endfunction

endpackage

// File: rtl/detector_linhas.sv
// Combinational line detector for a 3x3 board: flags a completed line for the
// given player and whether every cell is occupied.
module detector_linhas
    import jogo_pkg::*;
(
    input  logic [8:0][1:0] celulas,
    input  logic [1:0]      jogador,
    output logic            venceu,
    output logic            cheio
);

    logic [NUM_LINHAS-1:0]  linha_ok;
    logic [NUM_CELULAS-1:0] ocupada;

    generate
        for (genvar gi = 0; gi < NUM_LINHAS; gi++) begin : g_linha
            assign linha_ok[gi] = (celulas[LINHAS[gi][0]] == jogador) &&
                                  (celulas[LINHAS[gi][1]] == jogador) &&
                                  (celulas[LINHAS[gi][2]] == jogador);
        end
        for (genvar gi = 0; gi < NUM_CELULAS; gi++) begin : g_ocupada
            // 11 never appears in the board but still counts as occupied.
            assign ocupada[gi] = (celulas[gi] != VAZIO);
        end
    endgenerate

    assign venceu = jogador_valido(jogador) && (|linha_ok);
    assign cheio  = &ocupada;

endmodule

// File: rtl/verificador_vitoria.sv
// Serially reads the nine micro cells of one macro cell, decides win/draw for
// the player who just moved and writes the outcome to ram_board_state.
module verificador_vitoria
    import jogo_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic [3:0] addr_macro,
    input  logic [1:0] jogador,
    output logic [3:0] rd_addr_macro,
    output logic [3:0] rd_addr_micro,
    input  logic [1:0] rd_data,
    output logic       we_state,
    output logic [3:0] state_addr,
    output logic [1:0] state_data,
    output logic       ocupado,
    output logic       pronto,
    output logic [1:0] resultado
);

    estado_t         state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      macro_q, macro_d;
    logic [3:0]      micro_q, micro_d;
    logic [1:0]      jog_q, jog_d;
    logic [1:0]      res_q, res_d;
    logic [1:0]      resultado_q, resultado_d;
    logic [1:0]      state_data_q, state_data_d;
    logic            we_q, we_d;
    logic            ocupado_q, ocupado_d;
    logic            pronto_q, pronto_d;
    logic [8:0][1:0] cel_q, cel_d;

    logic       venceu, cheio;
    logic [1:0] res_comb;

    detector_linhas u_detector (
        .celulas (cel_q),
        .jogador (jog_q),
        .venceu  (venceu),
        .cheio   (cheio)
    );

    always_comb begin
        res_comb = ANDAMENTO;
        if (jogador_valido(jog_q)) begin
            if (venceu)
                res_comb = jog_q;
            else if (cheio)
                res_comb = VELHA;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= OCIOSO;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:  if (iniciar && (addr_macro <= 4'd8)) state_d = LEITURA;
            LEITURA: if (idx_q == 4'd9) state_d = AVALIA;
            AVALIA:  state_d = ESCREVE;
            ESCREVE: state_d = FIM;
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    // Outputs are registered, so each _d is derived from the upcoming state.
    always_comb begin
        idx_d        = idx_q;
        macro_d      = macro_q;
        micro_d      = micro_q;
        jog_d        = jog_q;
        res_d        = res_q;
        resultado_d  = resultado_q;
        state_data_d = state_data_q;
        cel_d        = cel_q;
        ocupado_d    = (state_d != OCIOSO);
        pronto_d     = (state_d == FIM);
        we_d         = (state_q == AVALIA) && (res_comb != ANDAMENTO);

        if ((state_q == OCIOSO) && (state_d == LEITURA)) begin
            macro_d = addr_macro;
            jog_d   = jogador;
            idx_d   = 4'd0;
        end

        if (state_q == LEITURA) begin
            idx_d = idx_q + 4'd1;
            // rd_data belongs to the address issued in the previous cycle.
            for (int i = 0; i < NUM_CELULAS; i++) begin
                if (idx_q == 4'(i + 1))
                    cel_d[i] = rd_data;
            end
        end

        if (state_d == LEITURA)
            micro_d = (idx_d > 4'd8) ? 4'd8 : idx_d;

        if (state_q == AVALIA) begin
            res_d = res_comb;
            if (res_comb != ANDAMENTO)
                state_data_d = res_comb;
        end

        if (state_q == ESCREVE)
            resultado_d = res_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= 4'd0;
            macro_q      <= 4'd0;
            micro_q      <= 4'd0;
            jog_q        <= VAZIO;
            res_q        <= ANDAMENTO;
            resultado_q  <= ANDAMENTO;
            state_data_q <= ANDAMENTO;
            we_q         <= 1'b0;
            ocupado_q    <= 1'b0;
            pronto_q     <= 1'b0;
            cel_q        <= '0;
        end else begin
            idx_q        <= idx_d;
            macro_q      <= macro_d;
            micro_q      <= micro_d;
            jog_q        <= jog_d;
            res_q        <= res_d;
            resultado_q  <= resultado_d;
            state_data_q <= state_data_d;
            we_q         <= we_d;
            ocupado_q    <= ocupado_d;
            pronto_q     <= pronto_d;
            cel_q        <= cel_d;
        end
    end

    assign rd_addr_macro = macro_q;
    assign rd_addr_micro = micro_q;
    assign state_addr    = macro_q;
    assign state_data    = state_data_q;
    assign we_state      = we_q;
    assign ocupado       = ocupado_q;
    assign pronto        = pronto_q;
    assign resultado     = resultado_q;

endmodule

// File: tb/tb_verificador_vitoria.sv
// Bench for verificador_vitoria: directed scenarios plus randomized boards
// compared against a behavioural tic-tac-toe referee.
module tb_verificador_vitoria;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       iniciar;
    logic [3:0] addr_macro;
    logic [1:0] jogador;
    logic [3:0] rd_addr_macro, rd_addr_micro, state_addr;
    logic [1:0] rd_data, state_data, resultado;
    logic       we_state, ocupado, pronto;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] mem [9][9];
    int         board [9];

    always #5 clock = ~clock;

    verificador_vitoria dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .iniciar       (iniciar),
        .addr_macro    (addr_macro),
        .jogador       (jogador),
        .rd_addr_macro (rd_addr_macro),
        .rd_addr_micro (rd_addr_micro),
        .rd_data       (rd_data),
        .we_state      (we_state),
        .state_addr    (state_addr),
        .state_data    (state_data),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .resultado     (resultado)
    );

    // ram_board model with registered read
    always @(posedge clock) begin
        if (rd_addr_macro < 4'd9 && rd_addr_micro < 4'd9)
            rd_data <= mem[int'(rd_addr_macro)][int'(rd_addr_micro)];
        else
            rd_data <= 2'b00;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Referee: does player j own a full row/column/diagonal, else is the board full
    function automatic logic [1:0] ref_result(input int b[9], input int j);
        bit win = 0;
        int filled = 0;
        if (j != 1 && j != 2) return 2'b00;
        for (int r = 0; r < 3; r++) begin
            if (b[3*r] == j && b[3*r+1] == j && b[3*r+2] == j) win = 1;
            if (b[r] == j && b[r+3] == j && b[r+6] == j) win = 1;
        end
        if (b[0] == j && b[4] == j && b[8] == j) win = 1;
        if (b[2] == j && b[4] == j && b[6] == j) win = 1;
        for (int i = 0; i < 9; i++) if (b[i] != 0) filled++;
        if (win) return 2'(j);
        if (filled == 9) return 2'b11;
        return 2'b00;
    endfunction

    task automatic load_board(input int m);
        for (int i = 0; i < 9; i++) mem[m][i] = 2'(board[i]);
    endtask

    task automatic set_board(input int c0, input int c1, input int c2, input int c3,
                             input int c4, input int c5, input int c6, input int c7, input int c8);
        board[0] = c0; board[1] = c1; board[2] = c2;
        board[3] = c3; board[4] = c4; board[5] = c5;
        board[6] = c6; board[7] = c7; board[8] = c8;
    endtask

    // Returns at the falling edge following the accepting rising edge (k=1).
    task automatic start_check(input int m, input int j);
        @(negedge clock);
        addr_macro = 4'(m);
        jogador    = 2'(j);
        iniciar    = 1'b1;
        @(negedge clock);
        iniciar    = 1'b0;
    endtask

    // Observes cycles k=1..15 after acceptance; k is the falling edge after rising edge t+k.
    task automatic observe(input string tag, input int m, input logic [1:0] exp, input bit repulse);
        int         we_cnt = 0;
        int         pr_cnt = 0;
        int         lat    = 0;
        logic [3:0] wa     = 4'd0;
        logic [1:0] wd     = 2'd0;
        logic [1:0] res_at = 2'd0;
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) @(negedge clock);
            if (we_state) begin
                we_cnt++;
                wa = state_addr;
                wd = state_data;
            end
            if (pronto) begin
                pr_cnt++;
                if (lat == 0) lat = k;
                res_at = resultado;
            end
            if (k == 1)  check_val({tag, "_ocupado_start"}, 32'(ocupado), 32'd1);
            if (k == 3)  check_val({tag, "_rd_addr_macro"}, 32'(rd_addr_macro), 32'(m));
            if (k == 14) check_val({tag, "_ocupado_after"}, 32'(ocupado), 32'd0);
            if (k == 15) check_val({tag, "_ocupado_k15"}, 32'(ocupado), 32'(repulse));
            if (repulse) begin
                if (k == 5 || k == 13) iniciar = 1'b1;
                if (k == 6 || k == 15) iniciar = 1'b0;
            end
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd13);
        check_val({tag, "_pronto_count"}, 32'(pr_cnt), 32'd1);
        check_val({tag, "_resultado"}, 32'(res_at), 32'(exp));
        check_val({tag, "_resultado_hold"}, 32'(resultado), 32'(exp));
        check_val({tag, "_we_count"}, 32'(we_cnt), (exp != 2'b00) ? 32'd1 : 32'd0);
        if (exp != 2'b00) begin
            check_val({tag, "_state_addr"}, 32'(wa), 32'(m));
            check_val({tag, "_state_data"}, 32'(wd), 32'(exp));
        end
        $display("[TB] %s macro=%0d expected=%0d got=%0d writes=%0d", tag, m, exp, res_at, we_cnt);
    endtask

    task automatic run_one(input string tag, input int m, input int j, input logic [1:0] exp);
        load_board(m);
        start_check(m, j);
        observe(tag, m, exp, 1'b0);
    endtask

    initial begin
        int busy_cnt, pr_cnt, we_cnt, m, j, jsel;
        logic [1:0] exp;

        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 9; b++) mem[a][b] = 2'b00;
        reset_n    = 1'b0;
        iniciar    = 1'b0;
        addr_macro = 4'd0;
        jogador    = 2'b00;
        repeat (3) @(negedge clock);
        check_val("rst_ocupado", 32'(ocupado), 32'd0);
        check_val("rst_pronto", 32'(pronto), 32'd0);
        check_val("rst_we_state", 32'(we_state), 32'd0);
        check_val("rst_resultado", 32'(resultado), 32'd0);
        check_val("rst_state_data", 32'(state_data), 32'd0);
        check_val("rst_rd_addr_macro", 32'(rd_addr_macro), 32'd0);
        check_val("rst_rd_addr_micro", 32'(rd_addr_micro), 32'd0);
        check_val("rst_state_addr", 32'(state_addr), 32'd0);
        reset_n = 1'b1;

        set_board(1, 1, 1, 0, 0, 0, 0, 0, 0);
        run_one("row_win", 4, 1, 2'b01);
        set_board(1, 1, 2, 0, 2, 0, 2, 0, 0);
        run_one("diag_p2", 2, 2, 2'b10);
        run_one("diag_p1", 2, 1, 2'b00);
        set_board(1, 2, 1, 1, 2, 2, 2, 1, 1);
        run_one("draw", 7, 1, 2'b11);
        set_board(1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_one("open", 0, 1, 2'b00);

        // macro address out of range must be ignored
        @(negedge clock);
        addr_macro = 4'd9;
        jogador    = 2'b01;
        iniciar    = 1'b1;
        @(negedge clock);
        iniciar  = 1'b0;
        busy_cnt = 0;
        pr_cnt   = 0;
        for (int k = 0; k < 15; k++) begin
            if (ocupado) busy_cnt++;
            if (pronto) pr_cnt++;
            @(negedge clock);
        end
        check_val("addr9_ocupado", 32'(busy_cnt), 32'd0);
        check_val("addr9_pronto", 32'(pr_cnt), 32'd0);
        $display("[TB] addr9 ignored busy=%0d pronto=%0d", busy_cnt, pr_cnt);

        // re-pulses during a check, then a back-to-back acceptance right after FIM
        set_board(2, 0, 0, 2, 0, 0, 2, 0, 0);
        load_board(6);
        start_check(6, 2);
        observe("repulse", 6, 2'b10, 1'b1);
        observe("back2back", 6, 2'b10, 1'b0);

        // reset during AVALIA aborts the write and the done pulse
        set_board(0, 0, 0, 1, 1, 1, 0, 0, 0);
        load_board(5);
        start_check(5, 1);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("abort_ocupado", 32'(ocupado), 32'd0);
        check_val("abort_we_state", 32'(we_state), 32'd0);
        check_val("abort_pronto", 32'(pronto), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        we_cnt  = 0;
        pr_cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (we_state) we_cnt++;
            if (pronto) pr_cnt++;
        end
        check_val("abort_no_write", 32'(we_cnt), 32'd0);
        check_val("abort_no_pronto", 32'(pr_cnt), 32'd0);
        check_val("abort_resultado", 32'(resultado), 32'd0);
        $display("[TB] abort writes=%0d pronto=%0d resultado=%0d", we_cnt, pr_cnt, resultado);

        for (int n = 0; n < 40; n++) begin
            m = int'($urandom_range(0, 8));
            for (int i = 0; i < 9; i++) board[i] = int'($urandom_range(0, 2));
            jsel = int'($urandom_range(0, 9));
            if (jsel == 0)      j = 0;
            else if (jsel == 1) j = 3;
            else                j = (jsel % 2 == 1) ? 1 : 2;
            exp = ref_result(board, j);
            run_one("random", m, j, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/verificador_vitoria.md
# verificador_vitoria

Downstream checker for the board datapath. After a move is written into a micro cell of `ram_board`, the control unit pulses `iniciar`. The block then serially reads the nine micro cells of the affected macro cell and evaluates the eight winning lines for the player who just moved. It writes the macro result (win or draw) into `ram_board_state` through its own write port. The `macro_vencida` and `fim_jogo` logic upstream consumes what this block stores.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `iniciar`  in  1  start pulse; sampled only in OCIOSO
- `addr_macro`  in  4  macro cell to check, 0–8; latched on accepted `iniciar`
- `jogador`  in  2  player who just moved (01 or 10); latched on accepted `iniciar`
- `rd_addr_macro`  out  4  read address to `ram_board` (latched macro cell)
- `rd_addr_micro`  out  4  read address to `ram_board`, micro cell 0–8
- `rd_data`  in  2  `ram_board` cell contents; registered read, valid one cycle after address
- `we_state`  out  1  write enable to `ram_board_state`
- `state_addr`  out  4  write address to `ram_board_state` (latched macro cell)
- `state_data`  out  2  value written: 01 P1 won, 10 P2 won, 11 draw
- `ocupado`  out  1  high from acceptance until the FIM cycle inclusive
- `pronto`  out  1  one-cycle done pulse
- `resultado`  out  2  last result (00 still open, 01, 10, 11); held until next accepted `iniciar`

## Operation
- Cell encoding: 00 empty, 01 P1, 10 P2; 11 is never stored and is treated as non-matching but occupied.
- FSM states: OCIOSO, LEITURA, AVALIA, ESCREVE, FIM.
- OCIOSO: `iniciar`=1 with `addr_macro`≤8 latches `addr_macro` and `jogador`, clears index to 0, and moves to LEITURA. `iniciar` with `addr_macro`>8 is ignored; the block stays idle with no pulse.
- LEITURA, 10 cycles, index 0..9:
  - `rd_addr_micro` = min(index, 8).
  - For index≥1, capture `rd_data` into `cel[index-1]`.
  - After index 9, go to AVALIA.
- AVALIA, 1 cycle, register the result:
  - 01/10 if the latched `jogador` fills any line (rows 012/345/678, columns 036/147/258, diagonals 048/246).
  - Otherwise 11 if all nine cells are non-zero.
  - Otherwise 00.
  - A latched `jogador` of 00 or 11 forces result 00.
- ESCREVE, 1 cycle: `we_state`=1 with `state_data`=result only if result≠00; otherwise `we_state` stays 0.
- FIM, 1 cycle: `pronto`=1, `resultado` updated, then return to OCIOSO.
- `iniciar` outside OCIOSO is ignored, including during FIM.
- `rd_addr_macro` and `state_addr` equal the latched macro cell while busy and hold their last value in OCIOSO.

## Timing
- Reset values:
  - State OCIOSO.
  - `ocupado`, `pronto`, `we_state` = 0.
  - `resultado`, `state_data` = 00.
  - All addresses = 0.
  - Cell shadow registers = 00.
- Reset mid-operation aborts immediately. No write is issued after reset, and no `pronto` pulse is produced for the aborted check.
- Accepted `iniciar` at edge t: LEITURA occupies cycles t+1..t+10, AVALIA t+11, ESCREVE t+12, FIM t+13 (`pronto` high).
- Fixed latency: 13 cycles from accepting edge to `pronto`. Back-to-back checks need `iniciar` in the cycle after FIM, for a minimum period of 14 cycles.
- All outputs are registered; `we_state`, `state_data`, and `state_addr` are stable together for the full ESCREVE cycle.
- `ram_board` must not be written while `ocupado`=1; the control unit guarantees this.

## Structure
- Shared package `jogo_pkg` holds:
  - Cell constants VAZIO=2'b00, JOG1=2'b01, JOG2=2'b10.
  - Macro-state constants ANDAMENTO=00, VENC1=01, VENC2=10, VELHA=11.
  - The eight-line index table LINHAS[8][3].
  - The FSM state enum.
- One combinational sub-module `detector_linhas`: inputs nine cells and a player, outputs `venceu` and `cheio`. It is reused by a future global-board checker.

## Test plan
- Row win: macro 4, cells 0,1,2=01, others 00, `jogador`=01, `iniciar` pulse. Expect `pronto` exactly 13 cycles later, one `we_state` pulse with addr 4 and data 01, `resultado`=01.
- Diagonal win for P2: cells 2,4,6=10, cells 0,1=01, `jogador`=10. Expect write data 10. Repeat with `jogador`=01 and expect result 00 with no write.
- Draw: full board 01 10 01 / 01 10 10 / 10 01 01, `jogador`=01. Expect `state_data`=11 and `we_state` pulse.
- Open cell: two P1 cells only. Expect `pronto`, `resultado`=00, `we_state` never high. `iniciar` with `addr_macro`=9: no `ocupado`, no `pronto`.
- `iniciar` re-pulsed at t+5 and t+13: ignored, exactly one `pronto`. `iniciar` at t+14: accepted.
- `reset_n` low at t+11: `ocupado`, `we_state`, `pronto` go 0 asynchronously. No write or `pronto` follows, and `resultado`=00.
